// File: rtl/fpu_issue_pkg.sv
// Shared definitions for the FPU issue controller and the fpu responder:
// opcodes, controller states and error codes.
package fpu_issue_pkg;

  localparam logic [4:0] OP_ITOF = 5'h10;
  localparam logic [4:0] OP_FTOI = 5'h11;
  localparam logic [4:0] OP_MULF = 5'h12;
  localparam logic [4:0] OP_RECF = 5'h13;
  localparam logic [4:0] OP_ADDF = 5'h14;
  localparam logic [4:0] OP_SUBF = 5'h15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_ERR   = 3'd4
  } issue_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_e;

  // ADDF/SUBF have opcodes but the attached FPU does not implement them.
  function automatic logic op_supported(input logic [4:0] op);
    return (op == OP_ITOF) || (op == OP_FTOI) || (op == OP_MULF) || (op == OP_RECF);
  endfunction

endpackage

// File: rtl/fpu_issue.sv
// Initiator side of the FPU en/done handshake: issues one instruction at a
// time, waits for done (with timeout) and returns the result on a writeback strobe.
module fpu_issue
  import fpu_issue_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [3:0]  req_rd,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        fpu_en,
  output logic [4:0]  fpu_instr,
  output logic [15:0] fpu_op1,
  output logic [15:0] fpu_op2,
  input  logic [15:0] fpu_result,
  input  logic        fpu_done,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        busy,
  output logic [3:0]  busy_rd,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  issue_state_e state;
  err_code_e    code_q;
  logic [3:0]   cnt;
  logic [4:0]   op_q;
  logic [3:0]   rd_q;
  logic [15:0]  a_q;
  logic [15:0]  b_q;
  logic [15:0]  wb_data_q;

  // NOTE: every register here, datapath latches included, is reset because
  // the outputs they drive must read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      code_q    <= ERR_NONE;
      cnt       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wb_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees pre-edge state.
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
            rd_q <= req_rd;
            a_q  <= req_a;
            b_q  <= req_b;
            if (op_supported(req_op)) begin
              state <= ST_ISSUE;
            end else begin
              state  <= ST_ERR;
              code_q <= ERR_ILLEGAL;
            end
          end
        end
        // done is ignored here: it may be stale until the FPU's first enabled edge.
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fpu_done) begin
            wb_data_q <= fpu_result;
            state     <= ST_WB;
          end else if (cnt == LAST_WAIT) begin
            code_q <= ERR_TIMEOUT;
            state  <= ST_ERR;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_WB:   state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Enable drops combinationally with done so the FPU never sees a second
  // enabled edge after completing.
  assign fpu_en    = (state == ST_ISSUE) || ((state == ST_WAIT) && !fpu_done);
  assign fpu_instr = op_q;
  assign fpu_op1   = a_q;
  assign fpu_op2   = b_q;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign busy_rd   = busy ? rd_q : 4'd0;

  assign wb_valid  = (state == ST_WB);
  assign wb_rd     = wb_valid ? rd_q : 4'd0;
  assign wb_data   = wb_data_q;

  assign err       = (state == ST_ERR);
  assign err_code  = err ? code_q : ERR_NONE;

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: bfloat16 FPU responder model, directed
// vector table, hand-written corner sequences and randomized transactions.
module tb_fpu_issue;
  import fpu_issue_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [3:0]  req_rd;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        fpu_en;
  logic [4:0]  fpu_instr;
  logic [15:0] fpu_op1;
  logic [15:0] fpu_op2;
  logic [15:0] fpu_result;
  logic        fpu_done;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        busy;
  logic [3:0]  busy_rd;
  logic        err;
  logic [1:0]  err_code;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpu_issue #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_a(req_a), .req_b(req_b),
    .fpu_en(fpu_en), .fpu_instr(fpu_instr), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2),
    .fpu_result(fpu_result), .fpu_done(fpu_done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .busy_rd(busy_rd), .err(err), .err_code(err_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bfloat16 arithmetic of the responder ----------------
  function automatic logic [15:0] bf_itof(input logic [15:0] x);
    logic [15:0] mag, sh;
    int p;
    if (x == 16'd0) return 16'd0;
    mag = x[15] ? 16'(-x) : x;
    p = 15;
    while (!mag[p]) p--;
    sh = mag << (15 - p);
    return {x[15], 8'(127 + p), sh[14:8]};
  endfunction

  function automatic logic [15:0] bf_ftoi(input logic [15:0] f);
    int e;
    logic [31:0] m, v;
    e = int'(f[14:7]);
    if (e < 127) return 16'd0;
    if (e > 141) e = 141;
    m = {24'd0, 1'b1, f[6:0]};
    v = (e - 127 >= 7) ? (m << (e - 134)) : (m >> (134 - e));
    return f[15] ? 16'(-v) : v[15:0];
  endfunction

  function automatic logic [15:0] bf_mulf(input logic [15:0] a, input logic [15:0] b);
    int e;
    logic [15:0] m;
    logic [6:0] mant;
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {a[15] ^ b[15], 15'd0};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    m = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
    if (m[15]) begin
      mant = m[14:8];
      e++;
    end else begin
      mant = m[13:7];
    end
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    return {a[15] ^ b[15], 8'(e), mant};
  endfunction

  function automatic logic [15:0] fpu_func(input logic [4:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    case (op)
      OP_ITOF: return bf_itof(b);
      OP_FTOI: return bf_ftoi(b);
      OP_MULF: return bf_mulf(a, b);
      OP_RECF: return 16'h7EFF - b;
      default: return 16'd0;
    endcase
  endfunction

  // Enabled edges the responder needs before raising done.
  function automatic int base_lat(input logic [4:0] op, input logic [15:0] b);
    case (op)
      OP_ITOF: return (b == 16'd0) ? 1 : 3;
      OP_FTOI: return b[15] ? 2 : 1;
      default: return 2;
    endcase
  endfunction

  // ---------------- FPU responder model (no reset, like the real one) ----------------
  logic        model_done = 1'b0;
  logic [15:0] model_res  = 16'd0;
  int          model_rem  = 0;
  int          model_extra = 0;
  logic        model_late = 1'b0;
  logic        en_q = 1'b0;

  assign fpu_done   = model_done;
  assign fpu_result = model_res;

  always @(posedge clk) begin
    en_q <= fpu_en;
    if (fpu_en && !en_q) begin
      model_res  <= fpu_func(fpu_instr, fpu_op1, fpu_op2);
      model_rem  <= base_lat(fpu_instr, fpu_op2) + model_extra - 1;
      model_done <= (base_lat(fpu_instr, fpu_op2) + model_extra == 1);
    end else if (fpu_en && model_rem != 0) begin
      model_rem <= model_rem - 1;
      if (model_rem == 1) model_done <= 1'b1;
    end else if (!fpu_en && model_late) begin
      model_done <= 1'b1;
    end
  end

  // ---------------- reference expectations from the timing rules ----------------
  typedef struct {
    int          lat;
    logic        is_err;
    logic [1:0]  code;
    logic [15:0] data;
  } expect_t;

  function automatic expect_t predict(input logic [4:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input int extra);
    expect_t r;
    int total;
    r.data = 16'd0;
    if (!(op inside {OP_ITOF, OP_FTOI, OP_MULF, OP_RECF})) begin
      r.lat = 0; r.is_err = 1'b1; r.code = 2'b01;
    end else begin
      total = base_lat(op, b) + extra;
      if (total <= TIMEOUT) begin
        r.lat = total + 1; r.is_err = 1'b0; r.code = 2'b00; r.data = fpu_func(op, a, b);
      end else begin
        r.lat = TIMEOUT + 1; r.is_err = 1'b1; r.code = 2'b10;
      end
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".fpu_en"},    32'(fpu_en),    32'd0);
    check({tag, ".fpu_instr"}, 32'(fpu_instr), 32'd0);
    check({tag, ".fpu_op1"},   32'(fpu_op1),   32'd0);
    check({tag, ".fpu_op2"},   32'(fpu_op2),   32'd0);
    check({tag, ".wb_valid"},  32'(wb_valid),  32'd0);
    check({tag, ".wb_rd"},     32'(wb_rd),     32'd0);
    check({tag, ".wb_data"},   32'(wb_data),   32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".busy_rd"},   32'(busy_rd),   32'd0);
    check({tag, ".err"},       32'(err),       32'd0);
    check({tag, ".err_code"},  32'(err_code),  32'd0);
  endtask

  // Issues one request at a negedge and follows it to its wb/err cycle.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [3:0] rd,
                        input logic [15:0] a, input logic [15:0] b, input int extra,
                        input expect_t ex, output int en_cycles);
    int n;
    bit seen;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
    check({tag, ".ready_before"}, 32'(req_ready), 32'd1);
    model_extra = extra;
    req_valid = 1'b1; req_op = op; req_rd = rd; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".busy"},    32'(busy),      32'd1);
    check({tag, ".busy_rd"}, 32'(busy_rd),   32'(rd));
    check({tag, ".ready"},   32'(req_ready), 32'd0);
    if (!ex.is_err || ex.code == 2'b10) begin
      check({tag, ".instr"}, 32'(fpu_instr), 32'(op));
      check({tag, ".op1"},   32'(fpu_op1),   32'(a));
      check({tag, ".op2"},   32'(fpu_op2),   32'(b));
    end
    n = 0; seen = 0; en_cycles = 0;
    while (n <= 40) begin
      if (wb_valid || err) begin
        seen = 1;
        break;
      end
      if (fpu_en) en_cycles++;
      if (req_ready || busy_rd != rd) begin
        check({tag, ".interlock"}, {27'd0, req_ready, busy_rd}, {28'd0, rd});
      end
      @(negedge clk);
      n++;
    end
    if (!seen) begin
      fails++; tests++;
      $display("FAIL %s.no_completion: no wb_valid/err within 40 cycles", tag);
    end else begin
      check({tag, ".latency"},  32'(n),        32'(ex.lat));
      check({tag, ".wb_valid"}, 32'(wb_valid), 32'(!ex.is_err));
      check({tag, ".err"},      32'(err),      32'(ex.is_err));
      check({tag, ".en_off"},   32'(fpu_en),   32'd0);
      if (ex.is_err) begin
        check({tag, ".err_code"}, 32'(err_code), 32'(ex.code));
      end else begin
        check({tag, ".wb_rd"},   32'(wb_rd),   32'(rd));
        check({tag, ".wb_data"}, 32'(wb_data), 32'(ex.data));
      end
    end
    @(negedge clk);
    check({tag, ".idle_after"}, {30'd0, wb_valid | err, req_ready}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    int          extra;
    int          lat;
    logic        is_err;
    logic [1:0]  code;
    logic [15:0] data;
    int          en_cyc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    expect_t ex;
    int en_cnt;
    logic [4:0] op;
    logic [15:0] b;
    int extra;

    vecs[0] = '{"itof5",    OP_ITOF, 4'd3,  16'h0000, 16'h0005, 0,  4,  1'b0, 2'b00, 16'h40A0, 3};
    vecs[1] = '{"ftoi_pos", OP_FTOI, 4'd1,  16'h1234, 16'h40A0, 0,  2,  1'b0, 2'b00, 16'h0005, 1};
    vecs[2] = '{"ftoi_neg", OP_FTOI, 4'd2,  16'h0000, 16'hC0A0, 0,  3,  1'b0, 2'b00, 16'hFFFB, 2};
    vecs[3] = '{"mulf",     OP_MULF, 4'd7,  16'h4000, 16'h4040, 0,  3,  1'b0, 2'b00, 16'h40C0, 2};
    vecs[4] = '{"addf",     OP_ADDF, 4'd4,  16'h4000, 16'h4040, 0,  0,  1'b1, 2'b01, 16'h0000, 0};
    vecs[5] = '{"subf",     OP_SUBF, 4'd5,  16'h4000, 16'h4040, 0,  0,  1'b1, 2'b01, 16'h0000, 0};
    vecs[6] = '{"itof0",    OP_ITOF, 4'd6,  16'hFFFF, 16'h0000, 0,  2,  1'b0, 2'b00, 16'h0000, 1};
    vecs[7] = '{"recf",     OP_RECF, 4'd9,  16'h0000, 16'h3F80, 0,  3,  1'b0, 2'b00, 16'h3F7F, 2};
    vecs[8] = '{"slow15",   OP_MULF, 4'd10, 16'h4000, 16'h4040, 13, 16, 1'b0, 2'b00, 16'h40C0, 15};
    vecs[9] = '{"slow16",   OP_MULF, 4'd11, 16'h4000, 16'h4040, 14, 16, 1'b1, 2'b10, 16'h0000, 16};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rd = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      ex = '{vecs[i].lat, vecs[i].is_err, vecs[i].code, vecs[i].data};
      run_op(vecs[i].name, vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].extra,
             ex, en_cnt);
      check({vecs[i].name, ".en_cycles"}, 32'(en_cnt), 32'(vecs[i].en_cyc));
    end

    // Hung FPU times out, then finishes late leaving done high while idle;
    // the next ITOF must not complete early on that stale done.
    ex = '{TIMEOUT + 1, 1'b1, 2'b10, 16'h0000};
    run_op("hang", OP_FTOI, 4'd8, 16'h0000, 16'h40A0, 40, ex, en_cnt);
    model_late = 1'b1;
    @(negedge clk);
    model_late = 1'b0;
    ex = '{4, 1'b0, 2'b00, 16'h40A0};
    run_op("stale_itof", OP_ITOF, 4'd3, 16'h0000, 16'h0005, 0, ex, en_cnt);
    check("stale_itof.en_cycles", 32'(en_cnt), 32'd3);

    // Asynchronous reset in the middle of WAIT.
    model_extra = 10;
    req_valid = 1'b1; req_op = OP_MULF; req_rd = 4'd12; req_a = 16'h4000; req_b = 16'h4040;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midwait.busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ex = '{3, 1'b0, 2'b00, 16'h40C0};
    run_op("after_reset", OP_MULF, 4'd12, 16'h4000, 16'h4040, 0, ex, en_cnt);

    // Randomized transactions against the timing rules.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: op = OP_ITOF;
        1: op = OP_FTOI;
        2: op = OP_MULF;
        3: op = OP_RECF;
        4: op = OP_ADDF;
        5: op = OP_SUBF;
        6: op = 5'($urandom_range(0, 15));
        default: op = OP_FTOI;
      endcase
      b = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 16)) : int'($urandom_range(0, 2));
      req_a = 16'($urandom);
      ex = predict(op, req_a, b, extra);
      run_op($sformatf("rnd%0d", i), op, 4'($urandom), req_a, b, extra, ex, en_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
